// File: rtl/present_sbox_layer_seq.sv
// PRESENT substitution layer sequencer: streams 16 nibbles of a 3-share state through one
// shared threshold S-box and reassembles the substituted shares, one share path per share.
module present_sbox_layer_seq #(
  parameter int NIBBLES  = 16,
  parameter int SBOX_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [4*NIBBLES-1:0]   state1_i,
  input  logic [4*NIBBLES-1:0]   state2_i,
  input  logic [4*NIBBLES-1:0]   state3_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [4*NIBBLES-1:0]   result1_o,
  output logic [4*NIBBLES-1:0]   result2_o,
  output logic [4*NIBBLES-1:0]   result3_o,
  output logic [3:0]             sbox_in1_o,
  output logic [3:0]             sbox_in2_o,
  output logic [3:0]             sbox_in3_o,
  input  logic [3:0]             sbox_out1_i,
  input  logic [3:0]             sbox_out2_i,
  input  logic [3:0]             sbox_out3_i
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FEED  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]      state;
  logic [CW-1:0]   feed_cnt;
  logic [CW-1:0]   cap_cnt;
  // Bit 0 marks a valid nibble on sbox_in*_o; bit SBOX_LAT marks its result on sbox_out*_i.
  logic [SBOX_LAT:0] vld_sr;

  logic [W-1:0] sr1_p0, sr2_p0, sr3_p0;
  logic [W-1:0] shadow1_p1, shadow2_p1, shadow3_p1;

  logic accept, feed_next, cap_vld, finish;

  assign accept    = (state == IDLE) && start_i;
  assign feed_next = accept || ((state == FEED) && (feed_cnt != LAST));
  assign cap_vld   = vld_sr[SBOX_LAT];
  assign finish    = (state == DRAIN) && cap_vld && (cap_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      feed_cnt <= '0;
      cap_cnt  <= '0;
      vld_sr   <= '0;
    end else begin
      vld_sr <= {vld_sr[SBOX_LAT-1:0], feed_next};
      done_o <= 1'b0;
      if (cap_vld) cap_cnt <= cap_cnt + 1'b1;
      case (state)
        IDLE: if (start_i) begin
          state    <= FEED;
          busy_o   <= 1'b1;
          feed_cnt <= '0;
          cap_cnt  <= '0;
        end
        FEED: begin
          if (feed_cnt == LAST) state <= DRAIN;
          else                  feed_cnt <= feed_cnt + 1'b1;
        end
        DRAIN: if (finish) begin
          state  <= DONE;
          done_o <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Stage p0: nibble feed, straight from flops so the S-box inputs never glitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr1_p0 <= '0; sr2_p0 <= '0; sr3_p0 <= '0;
      sbox_in1_o <= '0; sbox_in2_o <= '0; sbox_in3_o <= '0;
    end else if (accept) begin
      sbox_in1_o <= state1_i[3:0];
      sbox_in2_o <= state2_i[3:0];
      sbox_in3_o <= state3_i[3:0];
      sr1_p0 <= {4'b0, state1_i[W-1:4]};
      sr2_p0 <= {4'b0, state2_i[W-1:4]};
      sr3_p0 <= {4'b0, state3_i[W-1:4]};
    end else if (feed_next) begin
      sbox_in1_o <= sr1_p0[3:0];
      sbox_in2_o <= sr2_p0[3:0];
      sbox_in3_o <= sr3_p0[3:0];
      sr1_p0 <= {4'b0, sr1_p0[W-1:4]};
      sr2_p0 <= {4'b0, sr2_p0[W-1:4]};
      sr3_p0 <= {4'b0, sr3_p0[W-1:4]};
    end else begin
      sbox_in1_o <= '0;
      sbox_in2_o <= '0;
      sbox_in3_o <= '0;
    end
  end

  // Stage p1: capture into shadow regs from the MSB end so nibble 0 lands at [3:0].
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow1_p1 <= '0; shadow2_p1 <= '0; shadow3_p1 <= '0;
      result1_o  <= '0; result2_o  <= '0; result3_o  <= '0;
    end else begin
      if (cap_vld) begin
        shadow1_p1 <= {sbox_out1_i, shadow1_p1[W-1:4]};
        shadow2_p1 <= {sbox_out2_i, shadow2_p1[W-1:4]};
        shadow3_p1 <= {sbox_out3_i, shadow3_p1[W-1:4]};
      end
      if (finish) begin
        result1_o <= {sbox_out1_i, shadow1_p1[W-1:4]};
        result2_o <= {sbox_out2_i, shadow2_p1[W-1:4]};
        result3_o <= {sbox_out3_i, shadow3_p1[W-1:4]};
      end
    end
  end

endmodule

// File: tb/tb_present_sbox_layer_seq.sv
// Bench for present_sbox_layer_seq: a masked one-cycle S-box model plus a nibble-wise PRESENT
// reference layer; directed and random layers with cycle-exact busy/done/feed checks.
module tb_present_sbox_layer_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] state1, state2, state3;
  logic        busy, done;
  logic [63:0] result1, result2, result3;
  logic [3:0]  sbox_in1, sbox_in2, sbox_in3;
  logic [3:0]  sbox_out1, sbox_out2, sbox_out3;

  int total = 0;
  int bad   = 0;

  logic [3:0] sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                          4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  localparam logic [63:0] T1_IN  = 64'h0123456789ABCDEF;
  localparam logic [63:0] T1_OUT = 64'hC56B90AD3EF84712;

  always #5 clk = ~clk;

  present_sbox_layer_seq dut (
    .clk(clk), .rst_n(rst_n), .start_i(start),
    .state1_i(state1), .state2_i(state2), .state3_i(state3),
    .busy_o(busy), .done_o(done),
    .result1_o(result1), .result2_o(result2), .result3_o(result3),
    .sbox_in1_o(sbox_in1), .sbox_in2_o(sbox_in2), .sbox_in3_o(sbox_in3),
    .sbox_out1_i(sbox_out1), .sbox_out2_i(sbox_out2), .sbox_out3_i(sbox_out3)
  );

  // Shared S-box stand-in: one register of latency, output freshly re-masked every cycle.
  always @(posedge clk) begin
    logic [3:0] m2, m3;
    m2 = 4'($urandom);
    m3 = 4'($urandom);
    sbox_out1 <= sb[sbox_in1 ^ sbox_in2 ^ sbox_in3] ^ m2 ^ m3;
    sbox_out2 <= m2;
    sbox_out3 <= m3;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] present_layer(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = sb[x[4*i +: 4]];
    return r;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of cycle 19.
  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c, input logic [63:0] exp);
    state1 = a; state2 = b; state3 = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    state1 = rnd64(); state2 = rnd64(); state3 = rnd64();
    for (int n = 1; n <= 18; n++) begin
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_done"}, 64'(done), 64'(n == 18));
      if (n <= 16)
        chk({tag, "_feed"}, 64'({sbox_in1, sbox_in2, sbox_in3}),
            64'({a[4*(n-1) +: 4], b[4*(n-1) +: 4], c[4*(n-1) +: 4]}));
      else
        chk({tag, "_feed_idle"}, 64'({sbox_in1, sbox_in2, sbox_in3}), 64'd0);
      if (n == 18) chk({tag, "_result"}, result1 ^ result2 ^ result3, exp);
      @(negedge clk);
    end
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    chk({tag, "_done_end"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [63:0] s, s2, s3;
    int pulses, first_at, second_at, seen;
    rst_n = 1'b0; start = 1'b0;
    state1 = rnd64(); state2 = rnd64(); state3 = rnd64();
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_feed", 64'({sbox_in1, sbox_in2, sbox_in3}), 64'd0);
    chk("rst_result", result1 | result2 | result3, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("t1", T1_IN, 64'd0, 64'd0, T1_OUT);
    s2 = 64'hA5A5F00F1234DEAD;
    s3 = 64'h0F1E2D3C4B5A6978;
    do_op("t2", T1_IN ^ s2 ^ s3, s2, s3, T1_OUT);
    do_op("t3", 64'd0, 64'd0, 64'd0, 64'hCCCCCCCCCCCCCCCC);

    // Start held high: one accept per 19 cycles, nothing queued.
    state1 = T1_IN; state2 = 64'd0; state3 = 64'd0; start = 1'b1;
    pulses = 0; first_at = -1; second_at = -1;
    for (int n = 0; n <= 40; n++) begin
      if (done) begin
        pulses++;
        if (first_at < 0) first_at = n; else if (second_at < 0) second_at = n;
        chk("t4_result", result1 ^ result2 ^ result3, T1_OUT);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("t4_pulses", 64'(pulses), 64'd2);
    chk("t4_first", 64'(first_at), 64'd18);
    chk("t4_spacing", 64'(second_at - first_at), 64'd19);
    seen = 0;
    for (int n = 0; n < 30 && seen == 0; n++) begin
      if (done) seen = 1;
      @(negedge clk);
    end
    chk("t4_drain", 64'(seen), 64'd1);
    @(negedge clk);

    // Reset mid-layer discards the work.
    state1 = T1_IN; state2 = 64'd0; state3 = 64'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_feed", 64'({sbox_in1, sbox_in2, sbox_in3}), 64'd0);
    chk("t5_result", result1 | result2 | result3, 64'd0);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("t5_quiet", 64'(seen), 64'd0);
    do_op("t5_after", T1_IN, 64'd0, 64'd0, T1_OUT);

    for (int i = 0; i < 1000; i++) begin
      s  = rnd64();
      s2 = rnd64();
      s3 = rnd64();
      do_op("t6", s ^ s2 ^ s3, s2, s3, present_layer(s));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
